etc_planar_interp: RTL and testbench

- Stage directly downstream of the planar base-colour decoder.
- Accepts the three expanded RGB888 anchors: O = baseColor_0, H = baseColor_1, V = baseColor_2.
- Computes the 16 texels of the 4x4 ETC2 planar block and streams them one per cycle, with valid/ready handshake, to the texel writer.

---
 rtl/etc_planar_interp_pkg.sv | 26 ++
 rtl/etc_planar_channel.sv | 38 +++
 rtl/etc_planar_interp.sv | 107 ++++++++++
 tb/tb_etc_planar_interp.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/etc_planar_interp_pkg.sv
// Shared types and helpers for the ETC2 planar texel interpolator.
// Holds the FSM encoding, block geometry and the signed-to-u8 clamp.
package etc_planar_interp_pkg;

  localparam int ETC_CH_W         = 8;
  localparam int ETC_BLOCK_PIXELS = 16;

  typedef enum logic {
    ETC_PLN_IDLE = 1'b0,
    ETC_PLN_RUN  = 1'b1
  } etc_pln_state_e;

  // Saturate a 13-bit signed intermediate into an unsigned 8-bit channel.
  function automatic logic [ETC_CH_W-1:0] etc_clamp_u8(input logic signed [12:0] q);
    logic [ETC_CH_W-1:0] r;
    if (q < 13'sd0) begin
      r = 8'd0;
    end else if (q > 13'sd255) begin
      r = 8'd255;
    end else begin
      r = q[7:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/etc_planar_channel.sv
// One colour channel of the planar extrapolation: (x*dH + y*dV + 4*O + 2) >>> 2,
// clamped to 0..255. Purely combinational.
module etc_planar_channel
  import etc_planar_interp_pkg::*;
(
  input  logic [ETC_CH_W-1:0] o,
  input  logic [ETC_CH_W-1:0] h,
  input  logic [ETC_CH_W-1:0] v,
  input  logic [1:0]          x,
  input  logic [1:0]          y,
  output logic [ETC_CH_W-1:0] pix
);

  logic        [8:0]  dh_s;
  logic        [8:0]  dv_s;
  logic signed [12:0] dh_ext_s;
  logic signed [12:0] dv_ext_s;
  logic signed [12:0] x_ext_s;
  logic signed [12:0] y_ext_s;
  logic signed [12:0] o4_s;
  logic signed [12:0] sum_s;
  logic signed [12:0] q_s;

  // Sign-extend the 9-bit deltas so the products stay correct in 13 bits.
  always_comb begin
    dh_s     = {1'b0, h} - {1'b0, o};
    dv_s     = {1'b0, v} - {1'b0, o};
    dh_ext_s = {{4{dh_s[8]}}, dh_s};
    dv_ext_s = {{4{dv_s[8]}}, dv_s};
    x_ext_s  = {11'd0, x};
    y_ext_s  = {11'd0, y};
    o4_s     = {3'd0, o, 2'd0};
    sum_s    = x_ext_s * dh_ext_s + y_ext_s * dv_ext_s + o4_s + 13'sd2;
    q_s      = sum_s >>> 2;
    pix      = etc_clamp_u8(q_s);
  end

endmodule

// File: rtl/etc_planar_interp.sv
// ETC2 planar block interpolator: latches O/H/V anchors and streams the 16
// texels column-major (idx = x*4+y) over a valid/ready handshake.
module etc_planar_interp
  import etc_planar_interp_pkg::*;
#(
  parameter int CH_W  = 8,
  parameter int PIX_N = 16
) (
  input  logic                       sclk,
  input  logic                       rsrt,
  input  logic                       color_rts,
  input  logic [3*CH_W-1:0]          baseColor_0,
  input  logic [3*CH_W-1:0]          baseColor_1,
  input  logic [3*CH_W-1:0]          baseColor_2,
  output logic                       rtr,
  output logic                       pix_rts,
  input  logic                       pix_rtr,
  output logic [3*CH_W-1:0]          pix_data,
  output logic [$clog2(PIX_N)-1:0]   pix_idx,
  output logic                       pix_last
);

  localparam int                CNT_W    = $clog2(PIX_N);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PIX_N - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  etc_pln_state_e    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3*CH_W-1:0] o_q, o_d;
  logic [3*CH_W-1:0] h_q, h_d;
  logic [3*CH_W-1:0] v_q, v_d;

  // State, counter and anchor registers; reset wins over an accept.
  always_ff @(posedge sclk) begin
    if (rsrt) begin
      state_q <= ETC_PLN_IDLE;
      cnt_q   <= '0;
      o_q     <= '0;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  // Next-state logic: accept in IDLE, advance on each texel transfer in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    o_d     = o_q;
    h_d     = h_q;
    v_d     = v_q;
    case (state_q)
      ETC_PLN_IDLE: begin
        if (color_rts) begin
          o_d     = baseColor_0;
          h_d     = baseColor_1;
          v_d     = baseColor_2;
          cnt_d   = '0;
          state_d = ETC_PLN_RUN;
        end else begin
          state_d = ETC_PLN_IDLE;
        end
      end
      ETC_PLN_RUN: begin
        if (pix_rtr) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ETC_PLN_IDLE;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ETC_PLN_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Handshake and index outputs depend only on registered state.
  always_comb begin
    rtr      = (state_q == ETC_PLN_IDLE);
    pix_rts  = (state_q == ETC_PLN_RUN);
    pix_idx  = cnt_q;
    pix_last = (cnt_q == CNT_LAST) && (state_q == ETC_PLN_RUN);
  end

  for (genvar c = 0; c < 3; c++) begin : g_chan
    etc_planar_channel u_chan (
      .o   (o_q[c*CH_W +: CH_W]),
      .h   (h_q[c*CH_W +: CH_W]),
      .v   (v_q[c*CH_W +: CH_W]),
      .x   (cnt_q[3:2]),
      .y   (cnt_q[1:0]),
      .pix (pix_data[c*CH_W +: CH_W])
    );
  end

endmodule

// File: tb/tb_etc_planar_interp.sv
// Scoreboard bench for etc_planar_interp: stimulus pushes hand-computed
// texels, a negedge monitor pops and compares every transferred texel.
module tb_etc_planar_interp;

  logic        sclk = 1'b0;
  logic        rsrt;
  logic        color_rts;
  logic [23:0] b0, b1, b2;
  logic        rtr;
  logic        pix_rts;
  logic        pix_rtr;
  logic [23:0] pix_data;
  logic [3:0]  pix_idx;
  logic        pix_last;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [23:0] data;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  exp_t exp_q[$];

  // Channel value indexed by x (gradient) or by x+y (clamp cases).
  logic [7:0] rg_tbl [0:3] = '{8'd0, 8'd64, 8'd128, 8'd191};
  logic [7:0] up_tbl [0:6] = '{8'd0, 8'd64, 8'd128, 8'd191, 8'd255, 8'd255, 8'd255};
  logic [7:0] lo_tbl [0:6] = '{8'd255, 8'd191, 8'd128, 8'd64, 8'd0, 8'd0, 8'd0};

  etc_planar_interp dut (
    .sclk        (sclk),
    .rsrt        (rsrt),
    .color_rts   (color_rts),
    .baseColor_0 (b0),
    .baseColor_1 (b1),
    .baseColor_2 (b2),
    .rtr         (rtr),
    .pix_rts     (pix_rts),
    .pix_rtr     (pix_rtr),
    .pix_data    (pix_data),
    .pix_idx     (pix_idx),
    .pix_last    (pix_last)
  );

  always #5 sclk = ~sclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push_block(input int kind);
    for (int i = 0; i < 16; i++) begin
      int         x;
      int         y;
      logic [7:0] v;
      exp_t       e;
      x = i >> 2;
      y = i & 3;
      case (kind)
        0: e.data = 24'h102030;
        1: e.data = {16'h0000, rg_tbl[x]};
        2: begin v = up_tbl[x + y]; e.data = {v, v, v}; end
        default: begin v = lo_tbl[x + y]; e.data = {v, v, v}; end
      endcase
      e.idx  = 4'(i);
      e.last = (i == 15);
      exp_q.push_back(e);
    end
  endtask

  // Issue one accept cycle; called at posedge+1.
  task automatic accept(input logic [23:0] o, input logic [23:0] h,
                        input logic [23:0] v, input int kind);
    chk("rtr_before_accept", {31'd0, rtr}, 32'd1);
    b0 = o; b1 = h; b2 = v;
    color_rts = 1'b1;
    push_block(kind);
    @(posedge sclk); #1;
    color_rts = 1'b0;
  endtask

  task automatic drain(output int cycles);
    cycles = 0;
    while (exp_q.size() != 0 && cycles < 200) begin
      @(posedge sclk);
      cycles++;
    end
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: %0d texels outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    chk("rtr_after_block", {31'd0, rtr}, 32'd1);
    chk("rts_after_block", {31'd0, pix_rts}, 32'd0);
  endtask

  task automatic wait_idx(input logic [3:0] idx);
    int t;
    t = 0;
    while (!(pix_rts && pix_idx == idx) && t < 100) begin
      @(posedge sclk); #1;
      t++;
    end
    if (t >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_idx_timeout: idx %0d not presented, got idx %0d", idx, pix_idx);
    end
  endtask

  // Monitor: compare every texel accepted by the downstream side.
  always @(negedge sclk) begin
    exp_t e;
    if (!rsrt && pix_rts && pix_rtr) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_texel: idx %0d data 0x%06h, expected none", pix_idx, pix_data);
      end else begin
        e = exp_q.pop_front();
        chk("texel_idx",  {28'd0, pix_idx},  {28'd0, e.idx});
        chk("texel_data", {8'd0, pix_data},  {8'd0, e.data});
        chk("texel_last", {31'd0, pix_last}, {31'd0, e.last});
      end
    end
  end

  initial begin
    int cyc;
    rsrt = 1'b1; color_rts = 1'b0; pix_rtr = 1'b1;
    b0 = 24'h0; b1 = 24'h0; b2 = 24'h0;
    repeat (3) @(posedge sclk);
    #1;
    chk("reset_rtr",  {31'd0, rtr},      32'd1);
    chk("reset_rts",  {31'd0, pix_rts},  32'd0);
    chk("reset_data", {8'd0, pix_data},  32'd0);
    chk("reset_idx",  {28'd0, pix_idx},  32'd0);
    chk("reset_last", {31'd0, pix_last}, 32'd0);
    rsrt = 1'b0;
    @(posedge sclk); #1;

    // Flat block, continuous ready: 16 transfers in 16 cycles after accept.
    accept(24'h102030, 24'h102030, 24'h102030, 0);
    drain(cyc);
    chk("flat_cycles", 32'(cyc), 32'd16);

    // R gradient with a 5-cycle stall at idx 7 and a stray color_rts.
    accept(24'h000000, 24'h0000FF, 24'h000000, 1);
    wait_idx(4'd7);
    pix_rtr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 0) begin
        b0 = 24'hFFFFFF; b1 = 24'hFFFFFF; b2 = 24'hFFFFFF;
        color_rts = 1'b1;
      end
      @(posedge sclk); #1;
      color_rts = 1'b0;
      chk("stall_idx",  {28'd0, pix_idx},  32'd7);
      chk("stall_data", {8'd0, pix_data},  32'h000040);
      chk("stall_rts",  {31'd0, pix_rts},  32'd1);
      chk("stall_rtr",  {31'd0, rtr},      32'd0);
    end
    pix_rtr = 1'b1;
    drain(cyc);

    // Upper and lower clamp blocks.
    accept(24'h000000, 24'hFFFFFF, 24'hFFFFFF, 2);
    drain(cyc);
    accept(24'hFFFFFF, 24'h000000, 24'h000000, 3);
    drain(cyc);

    // Reset at idx 9 together with an accept attempt: nothing latched.
    accept(24'h000000, 24'hFFFFFF, 24'hFFFFFF, 2);
    wait_idx(4'd9);
    rsrt = 1'b1;
    b0 = 24'h123456; b1 = 24'h654321; b2 = 24'hABCDEF;
    color_rts = 1'b1;
    @(posedge sclk); #1;
    rsrt = 1'b0;
    color_rts = 1'b0;
    exp_q.delete();
    chk("midrun_reset_rts",  {31'd0, pix_rts},  32'd0);
    chk("midrun_reset_rtr",  {31'd0, rtr},      32'd1);
    chk("midrun_reset_data", {8'd0, pix_data},  32'd0);
    chk("midrun_reset_idx",  {28'd0, pix_idx},  32'd0);
    chk("midrun_reset_last", {31'd0, pix_last}, 32'd0);
    @(posedge sclk); #1;
    chk("post_reset_idle", {31'd0, pix_rts}, 32'd0);

    accept(24'hFFFFFF, 24'h000000, 24'h000000, 3);
    drain(cyc);
    chk("restart_cycles", 32'(cyc), 32'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
